// File: rtl/aes_pkg.sv
// aes_pkg: shared AES op encoding and illegal-op decode
package aes_pkg;

    localparam int AES_OP_WIDTH = 2;

    typedef enum logic [AES_OP_WIDTH-1:0] {
        CIPH_FWD = 2'b01,
        CIPH_INV = 2'b10
    } ciph_op_e;

    // Only the two cipher directions are legal; 2'b00 and 2'b11 flag an error
    function automatic logic op_illegal(input logic [AES_OP_WIDTH-1:0] op);
        return !(op == CIPH_FWD || op == CIPH_INV);
    endfunction

endpackage

// File: rtl/aes_sbox_canright.sv
// aes_sbox_canright: combinational AES S-box, forward or inverse selected by op
module aes_sbox_canright
    import aes_pkg::*;
(
    input  logic [AES_OP_WIDTH-1:0] i_op,
    input  logic [7:0]              i_data,
    output logic [7:0]              o_data
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 naturally)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] w_fwd_inv;
    logic [7:0] w_fwd;
    logic [7:0] w_inv_pre;
    logic [7:0] w_inv;

    // Forward: invert then affine; inverse: inverse affine then invert
    always_comb begin
        w_fwd_inv = gf_inv(i_data);
        w_fwd     = w_fwd_inv ^ {w_fwd_inv[6:0], w_fwd_inv[7]} ^ {w_fwd_inv[5:0], w_fwd_inv[7:6]}
                  ^ {w_fwd_inv[4:0], w_fwd_inv[7:5]} ^ {w_fwd_inv[3:0], w_fwd_inv[7:4]} ^ 8'h63;
        w_inv_pre = {i_data[6:0], i_data[7]} ^ {i_data[4:0], i_data[7:5]}
                  ^ {i_data[1:0], i_data[7:2]} ^ 8'h05;
        w_inv     = gf_inv(w_inv_pre);
        o_data    = (i_op == CIPH_INV) ? w_inv : w_fwd;
    end

endmodule

// File: rtl/aes_sbox_arbiter.sv
// aes_sbox_arbiter: round-robin sharing of one S-box with a registered response stage
module aes_sbox_arbiter
    import aes_pkg::*;
#(
    parameter  int NumReq = 4,
    localparam int IdW    = $clog2(NumReq)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic [NumReq-1:0]              req_valid_i,
    output logic [NumReq-1:0]              req_ready_o,
    input  logic [NumReq*AES_OP_WIDTH-1:0] req_op_i,
    input  logic [NumReq*8-1:0]            req_data_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [IdW-1:0]                 rsp_id_o,
    output logic [7:0]                     rsp_data_o,
    output logic                           rsp_err_o,
    output logic                           busy_o
);

    logic [IdW-1:0]          r_ptr;
    logic                    r_valid;
    logic [7:0]              r_data;
    logic [IdW-1:0]          r_id;
    logic                    r_err;
    logic                    w_free;
    logic                    w_accept;
    logic                    w_gnt_vld;
    logic [IdW-1:0]          w_gnt;
    logic [IdW-1:0]          w_idx;
    logic [AES_OP_WIDTH-1:0] w_op;
    logic [7:0]              w_din;
    logic [7:0]              w_sbox;
    logic                    w_err;

    assign w_free   = !r_valid | rsp_ready_i;
    assign w_accept = w_free & !clear_i & w_gnt_vld;
    assign w_op     = req_op_i[{w_gnt, 1'b0} +: AES_OP_WIDTH];
    assign w_din    = req_data_i[{w_gnt, 3'b000} +: 8];
    assign w_err    = op_illegal(w_op);

    // Search from ptr upward; scanning backwards lets the nearest valid lane win last
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_idx     = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            w_idx = IdW'((int'(r_ptr) + k) % NumReq);
            if (req_valid_i[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
    end

    // Ready only toward the granted lane, and only when the stage can take it
    always_comb begin
        req_ready_o        = '0;
        req_ready_o[w_gnt] = w_accept;
    end

    aes_sbox_canright u_sbox (
        .i_op   (w_op),
        .i_data (w_din),
        .o_data (w_sbox)
    );

    // Output stage and pointer: clear beats accept, accept beats drain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
            r_id    <= '0;
            r_err   <= 1'b0;
            r_ptr   <= '0;
        end else if (clear_i) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_err ? 8'h00 : w_sbox;
            r_id    <= w_gnt;
            r_err   <= w_err;
            r_ptr   <= (w_gnt == IdW'(NumReq - 1)) ? '0 : w_gnt + IdW'(1);
        end else if (rsp_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign rsp_valid_o = r_valid;
    assign rsp_data_o  = r_data;
    assign rsp_id_o    = r_id;
    assign rsp_err_o   = r_err;
    assign busy_o      = r_valid;

endmodule

// File: doc/aes_sbox_arbiter.md
Name: aes_sbox_arbiter

Overview:
- Shares one combinational `aes_sbox_canright` instance between NumReq requesters, for example the SubBytes lanes and the key-expansion SubWord path.
- Arbitration is round-robin; each requester has a valid/ready handshake.
- One output register stage carries the result, the winning requester index and an error flag to a single downstream consumer with backpressure.
- Sits between the cipher/key-expand control logic and the shared S-box datapath.

Parameters:
- NumReq, 4, number of requesters (2..8).
- IdW, $clog2(NumReq), width of the requester index (derived localparam, not overridable).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous assert, active-low.
- clear_i  input  1  synchronous flush of the output stage and arbitration pointer.
- req_valid_i  input  NumReq  per-requester request valid.
- req_ready_o  output  NumReq  per-requester grant/accept (one-hot or zero).
- req_op_i  input  NumReq*2  per-requester op (aes_pkg encoding); lane i at [2i+1:2i].
- req_data_i  input  NumReq*8  per-requester input byte; lane i at [8i+7:8i].
- rsp_valid_o  output  1  response valid (registered).
- rsp_ready_i  input  1  downstream accepts the response.
- rsp_id_o  output  IdW  index of the requester that produced the response.
- rsp_data_o  output  8  S-box result byte.
- rsp_err_o  output  1  request carried an illegal op.
- busy_o  output  1  output stage occupied (equals rsp_valid_o).

Behaviour:
- Reset (rst_ni low, asynchronous):
  - rsp_valid_o=0, rsp_data_o=8'h00, rsp_id_o=0, rsp_err_o=0.
  - Round-robin pointer ptr=0.
  - req_ready_o is combinational and therefore 0 while the output stage is full.
- Stage-free condition: free = !rsp_valid_o | rsp_ready_i. A drain and a new accept in the same cycle is allowed, giving full throughput of 1 byte/cycle.
- Arbitration (combinational):
  - When free & !clear_i, grant the first lane with req_valid_i set, searching ptr, ptr+1, ... modulo NumReq.
  - req_ready_o[g]=1 for the granted lane only; all others are 0.
  - No grant if no lane is valid.
- Ready vs. valid: req_ready_o may depend on req_valid_i of all lanes. Requesters must not make req_valid_i depend on req_ready_o.
- Handshake: the request on lane g is accepted when req_valid_i[g] & req_ready_o[g]. A requester holds op/data stable while valid and not accepted.
- Ptr update: on accept of lane g, ptr <= (g+1) mod NumReq (wrap at NumReq-1 → 0). Otherwise ptr holds.
- Latency: an accept in cycle t drives the following in cycle t+1 (1-cycle latency):
  - rsp_valid_o=1;
  - rsp_data_o = sbox(op_g, data_g);
  - rsp_id_o = g;
  - rsp_err_o = (op_g ∉ {CIPH_FWD, CIPH_INV}).
- Illegal op (2'b00 or 2'b11): the request is still accepted, rsp_data_o=8'h00, rsp_err_o=1. The S-box output is masked, not passed through.
- Hold: while rsp_valid_o & !rsp_ready_i, all rsp_* outputs are stable and req_ready_o is all-zero.
- Drain without refill: rsp_valid_o & rsp_ready_i with no accept → rsp_valid_o<=0 next cycle. rsp_data_o/rsp_id_o/rsp_err_o keep their last values.
- clear_i (highest priority after reset):
  - Next cycle rsp_valid_o=0, rsp_err_o=0, ptr=0.
  - req_ready_o is all-zero during the clear cycle, so no request is accepted then.
- Fairness bound: with all lanes continuously valid and rsp_ready_i=1, each lane is granted exactly once every NumReq cycles.

Decomposition:
- aes_pkg holds:
  - AES_OP_WIDTH;
  - op encoding CIPH_FWD=2'b01, CIPH_INV=2'b10;
  - the function used to decode illegal ops.
- Arbiter-local: localparam IdW, and the round-robin pointer register type logic [IdW-1:0].
- Sub-module: exactly one instance of the existing `aes_sbox_canright`, fed by the muxed op/data of the granted lane. The round-robin picker stays inline; no separate module is needed.

Test Plan:
- Reset then single lane 0: op=01, data=8'h00 → next cycle rsp_valid_o=1, rsp_data_o=8'h63, rsp_id_o=0, rsp_err_o=0. Then lane 0: op=01, data=8'h53 → 8'hED.
- Inverse on lane 2: op=10, data=8'hED → 8'h53, rsp_id_o=2. Then op=10, data=8'h63 → 8'h00.
- All 4 lanes valid continuously with data = 8'h01 on lane 0 and 0 elsewhere, op=01, rsp_ready_i=1:
  - rsp_id_o sequence 0,1,2,3,0,... ;
  - lane 0 result 8'h7C, other lanes 8'h63;
  - no bubbles.
- Backpressure: rsp_ready_i=0 for 3 cycles with lanes 1 and 3 valid:
  - response frozen and req_ready_o=0 during the stall;
  - on release, next grant follows ptr order;
  - no lost or duplicated responses (scoreboard by id).
- Illegal op=2'b11, data=8'h53 on lane 1 → rsp_err_o=1, rsp_data_o=8'h00, rsp_id_o=1. Next legal request clears rsp_err_o.
- clear_i while rsp_valid_o=1 and rsp_ready_i=0 → rsp_valid_o=0 next cycle, ptr=0, lane 0 granted first afterwards. Separately, assert rst_ni low mid-stream → all outputs 0 immediately, without waiting for a clock edge.
